dmem_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared data-memory window 0x8F11..0x9310.
- Port 0 is the CPU load/store path; port 1 is the DMA/debug path.
- Grants one transaction at a time with round-robin priority and performs address-window decode. For each granted in-window access it drives the memory CS, iWE and the window-relative iAddress, then waits a fixed memory latency.
- Out-of-window requests are answered with an error and never reach memory.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the data memory.
// The master modport is the testbench/system side (requests plus memory read
// data); the slave modport is the arbiter itself.
interface dmem_arbiter_if;
    // Master 0 (CPU) and master 1 (DMA/debug) request side
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;

    // Response side back to the masters
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err;
    logic [31:0] rdata;

    // Memory side
    logic        CS;
    logic        iWE;
    logic [31:0] iAddress;
    logic [31:0] mwdata;
    logic [31:0] mrdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mrdata,
        input  gnt0, gnt1, done0, done1, err, rdata, CS, iWE, iAddress, mwdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mrdata,
        output gnt0, gnt1, done0, done1, err, rdata, CS, iWE, iAddress, mwdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared data-memory
// window. One transaction at a time: grant, decode the window, drive the
// memory for MEM_LAT cycles, then pulse done on the granted port.
// Every output is a flop, so all outputs change only on the rising edge.
module dmem_arbiter #(
    parameter logic [31:0] LOWER_ADDR = 32'h0000_8F11,
    parameter logic [31:0] UPPER_ADDR = 32'h0000_9310,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic          CLK,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter value loaded on leaving ACCESS: the remaining CS cycles
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        sel_q,        sel_d;        // granted port of the current transaction
    logic        we_q,         we_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [3:0]  wait_cnt_q,   wait_cnt_d;

    logic        gnt0_q,   gnt0_d;
    logic        gnt1_q,   gnt1_d;
    logic        done0_q,  done0_d;
    logic        done1_q,  done1_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        cs_q,     cs_d;
    logic        iwe_q,    iwe_d;
    logic [31:0] iaddr_q,  iaddr_d;
    logic [31:0] mwdata_q, mwdata_d;

    logic        in_window;
    logic        pick1;
    logic        mem_done;

    // Unsigned window test on the latched address, both bounds inclusive
    assign in_window = (addr_q >= LOWER_ADDR) && (addr_q <= UPPER_ADDR);

    // Next-state and next-output logic for the transaction sequencer
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        cs_d         = cs_q;
        iwe_d        = iwe_q;
        iaddr_d      = iaddr_q;
        mwdata_d     = mwdata_q;
        pick1        = 1'b0;
        mem_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // With both requesting, the port that did not win last time goes
                    pick1        = bus.req1 && (!bus.req0 || !last_grant_q);
                    sel_d        = pick1;
                    last_grant_d = pick1;
                    we_d         = pick1 ? bus.we1    : bus.we0;
                    addr_d       = pick1 ? bus.addr1  : bus.addr0;
                    wdata_d      = pick1 ? bus.wdata1 : bus.wdata0;
                    gnt0_d       = !pick1;
                    gnt1_d       = pick1;
                    state_d      = S_DECODE;
                end
            end

            S_DECODE: begin
                if (in_window) begin
                    cs_d     = 1'b1;
                    iwe_d    = we_q;
                    iaddr_d  = addr_q - LOWER_ADDR;
                    mwdata_d = wdata_q;
                    state_d  = S_ACCESS;
                end else begin
                    // Miss never touches memory; answer straight away
                    err_d   = 1'b1;
                    done0_d = !sel_q;
                    done1_d = sel_q;
                    rdata_d = 32'd0;
                    state_d = S_RESP;
                end
            end

            S_ACCESS: begin
                if (MEM_LAT <= 1) begin
                    mem_done = 1'b1;
                end else begin
                    wait_cnt_d = LAT_M1;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d = 4'd0;
                    mem_done   = 1'b1;
                end
            end

            S_RESP: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                rdata_d = 32'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Last CS cycle: release the memory and take read data at this edge
        if (mem_done) begin
            cs_d     = 1'b0;
            iwe_d    = 1'b0;
            iaddr_d  = 32'd0;
            mwdata_d = 32'd0;
            rdata_d  = we_q ? 32'd0 : bus.mrdata;
            done0_d  = !sel_q;
            done1_d  = sel_q;
            state_d  = S_RESP;
        end
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wait_cnt_q   <= 4'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
            cs_q         <= 1'b0;
            iwe_q        <= 1'b0;
            iaddr_q      <= 32'd0;
            mwdata_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            cs_q         <= cs_d;
            iwe_q        <= iwe_d;
            iaddr_q      <= iaddr_d;
            mwdata_q     <= mwdata_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.CS       = cs_q;
    assign bus.iWE      = iwe_q;
    assign bus.iAddress = iaddr_q;
    assign bus.mwdata   = mwdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan steps plus randomized rounds,
// checked against a transaction-level model (window test, latency formula,
// round-robin winner). Extra instances cover MEM_LAT=1 and MEM_LAT=4.
module tb_dmem_arbiter;
    localparam logic [31:0] LOWER    = 32'h0000_8F11;
    localparam logic [31:0] UPPER    = 32'h0000_9310;
    localparam int          MAIN_LAT = 2;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    dmem_arbiter_if bi ();
    dmem_arbiter_if b1 ();
    dmem_arbiter_if b4 ();

    dmem_arbiter #(.LOWER_ADDR(LOWER), .UPPER_ADDR(UPPER), .MEM_LAT(MAIN_LAT)) dut (
        .CLK(CLK), .rst_n(rst_n), .bus(bi)
    );
    dmem_arbiter #(.LOWER_ADDR(LOWER), .UPPER_ADDR(UPPER), .MEM_LAT(1)) dut_lat1 (
        .CLK(CLK), .rst_n(rst_n), .bus(b1)
    );
    dmem_arbiter #(.LOWER_ADDR(LOWER), .UPPER_ADDR(UPPER), .MEM_LAT(4)) dut_lat4 (
        .CLK(CLK), .rst_n(rst_n), .bus(b4)
    );

    int          errors = 0;
    int          checks = 0;
    bit          exp_last;         // model: port granted last (reset value 1)
    logic [31:0] mr_cur;           // mrdata currently driven
    logic [31:0] prev_mr;          // mrdata present at the edge just passed

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then present new memory data
    task automatic tick();
        @(posedge CLK);
        #1;
        prev_mr = mr_cur;
        mr_cur  = $urandom();
        bi.mrdata = mr_cur;
        b1.mrdata = mr_cur;
        b4.mrdata = mr_cur;
        check1("gnt_onehot", bi.gnt0 & bi.gnt1, 1'b0);
        check1("iwe_without_cs", bi.iWE & ~bi.CS, 1'b0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 6))
            0: a = LOWER;
            1: a = UPPER;
            2: a = LOWER - 32'd1;
            3: a = UPPER + 32'd1;
            4: a = 32'hFFFF_FFFF;
            5: a = $urandom();
            default: a = LOWER + 32'($urandom_range(0, 32'h3FF));
        endcase
        return a;
    endfunction

    // One arbitration round on the main instance. cont=1 means the round
    // starts while the previous transaction is in its done cycle with the
    // requests still held, so one extra edge passes before IDLE samples.
    task automatic run_round(input bit r0, input bit r1,
                             input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                             input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                             input bit cont);
        bit          win;
        bit          hit;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          exp_tick;
        int          done_k;
        int          cs_cycles;
        win      = (r0 && r1) ? !exp_last : r1;
        exp_last = win;
        w        = win ? w1 : w0;
        a        = win ? a1 : a0;
        d        = win ? d1 : d0;
        hit      = (a >= LOWER) && (a <= UPPER);
        // Latency counts the req-sampling edge as 1 and ends at the edge that samples done
        exp_tick = (hit ? 3 + MAIN_LAT : 3) - 1 + (cont ? 1 : 0);
        bi.req0 = r0; bi.we0 = w0; bi.addr0 = a0; bi.wdata0 = d0;
        bi.req1 = r1; bi.we1 = w1; bi.addr1 = a1; bi.wdata1 = d1;
        done_k    = 0;
        cs_cycles = 0;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            tick();
            if (cont && k == 1) begin
                check1("idle_gap_gnt", bi.gnt0 | bi.gnt1, 1'b0);
                check1("done_single_cycle", bi.done0 | bi.done1, 1'b0);
            end
            if (bi.CS) begin
                cs_cycles++;
                check32("cs_iaddress", bi.iAddress, a - LOWER);
                check1("cs_iwe", bi.iWE, w);
                check32("cs_mwdata", bi.mwdata, d);
                check1("cs_gnt_winner", win ? bi.gnt1 : bi.gnt0, 1'b1);
            end
            if (bi.done0 || bi.done1) begin
                done_k = k;
                check1("done_winner", win ? bi.done1 : bi.done0, 1'b1);
                check1("done_loser", win ? bi.done0 : bi.done1, 1'b0);
                check1("gnt_at_done", win ? bi.gnt1 : bi.gnt0, 1'b1);
                check1("err", bi.err, !hit);
                check32("rdata", bi.rdata, (hit && !w) ? prev_mr : 32'd0);
                check_int("latency", done_k, exp_tick);
                check_int("cs_cycles", cs_cycles, hit ? MAIN_LAT : 0);
            end
        end
        if (done_k == 0) check_int("done_timeout", done_k, exp_tick);
        $display("txn port=%0d we=%0d addr=%h hit=%0d done_tick=%0d rdata=%h err=%0d",
                 win, w, a, hit, done_k, bi.rdata, bi.err);
    endtask

    task automatic drop_and_idle();
        bi.req0 = 1'b0;
        bi.req1 = 1'b0;
        tick();
        check1("done_single_cycle", bi.done0 | bi.done1, 1'b0);
        check1("gnt_released", bi.gnt0 | bi.gnt1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        exp_last = 1'b1;
    endtask

    initial begin
        int d1k;
        int d4k;
        int cs1;
        int cs4;
        int k;
        bit s0;
        bit s1;
        mr_cur = 32'd0;
        prev_mr = 32'd0;
        exp_last = 1'b1;
        bi.req0 = 0; bi.req1 = 0; bi.we0 = 0; bi.we1 = 0;
        bi.addr0 = 0; bi.addr1 = 0; bi.wdata0 = 0; bi.wdata1 = 0; bi.mrdata = 0;
        b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
        b1.addr0 = 0; b1.addr1 = 0; b1.wdata0 = 0; b1.wdata1 = 0; b1.mrdata = 0;
        b4.req0 = 0; b4.req1 = 0; b4.we0 = 0; b4.we1 = 0;
        b4.addr0 = 0; b4.addr1 = 0; b4.wdata0 = 0; b4.wdata1 = 0; b4.mrdata = 0;

        // Reset: every output low
        do_reset();
        check1("rst_gnt0", bi.gnt0, 1'b0);
        check1("rst_gnt1", bi.gnt1, 1'b0);
        check1("rst_done", bi.done0 | bi.done1, 1'b0);
        check1("rst_err", bi.err, 1'b0);
        check32("rst_rdata", bi.rdata, 32'd0);
        check1("rst_cs", bi.CS, 1'b0);
        check32("rst_iaddress", bi.iAddress, 32'd0);
        check32("rst_mwdata", bi.mwdata, 32'd0);

        // Read at lower bound, write at upper bound
        run_round(1, 0, 0, 32'h0000_8F11, 32'd0, 0, 32'd0, 32'd0, 0);
        drop_and_idle();
        run_round(0, 1, 0, 32'd0, 32'd0, 1, 32'h0000_9310, 32'h1234_5678, 0);
        drop_and_idle();

        // Out-of-window accesses
        run_round(1, 0, 0, 32'h0000_8F10, 32'd0, 0, 32'd0, 32'd0, 0);
        drop_and_idle();
        run_round(1, 0, 1, 32'h0000_9311, 32'hA5A5_A5A5, 0, 32'd0, 32'd0, 0);
        drop_and_idle();
        run_round(1, 0, 0, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'd0, 0);
        drop_and_idle();

        // Continuous contention after reset: grants alternate starting with port 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_round(1, 1, 1'($urandom_range(0, 1)), pick_addr(), $urandom(),
                      1'($urandom_range(0, 1)), pick_addr(), $urandom(), i != 0);
        end
        drop_and_idle();

        // Reset during WAIT of a port 1 read aborts with no done pulse
        bi.req1 = 1; bi.we1 = 0; bi.addr1 = 32'h0000_9000;
        k = 0;
        while (!bi.CS && k < 10) begin
            tick();
            k++;
        end
        check1("midwait_reached_access", bi.CS, 1'b1);
        tick();
        check1("midwait_cs_held", bi.CS, 1'b1);
        check1("midwait_no_done_yet", bi.done1, 1'b0);
        rst_n = 1'b0;
        tick();
        check1("abort_cs", bi.CS, 1'b0);
        check1("abort_gnt1", bi.gnt1, 1'b0);
        check1("abort_no_done1", bi.done1, 1'b0);
        rst_n = 1'b1;
        bi.req1 = 0;
        exp_last = 1'b1;
        tick();
        check1("abort_still_no_done1", bi.done1, 1'b0);
        run_round(1, 1, 0, 32'h0000_9100, 32'd0, 0, 32'h0000_9200, 32'd0, 0);
        drop_and_idle();

        // Randomized rounds against the model
        for (int i = 0; i < 40; i++) begin
            s0 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            if (!s0 && !s1) s0 = 1'b1;
            run_round(s0, s1, 1'($urandom_range(0, 1)), pick_addr(), $urandom(),
                      1'($urandom_range(0, 1)), pick_addr(), $urandom(), 0);
            drop_and_idle();
        end

        // MEM_LAT=1 and MEM_LAT=4 reads issued on the same edge
        b1.req0 = 1; b1.we0 = 0; b1.addr0 = 32'h0000_9000;
        b4.req0 = 1; b4.we0 = 0; b4.addr0 = 32'h0000_9000;
        d1k = 0; d4k = 0; cs1 = 0; cs4 = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (b1.CS) cs1++;
            if (b4.CS) cs4++;
            if (b1.done0 && d1k == 0) begin
                d1k = j;
                check32("lat1_rdata", b1.rdata, prev_mr);
                check1("lat1_err", b1.err, 1'b0);
                b1.req0 = 0;
            end
            if (b4.done0 && d4k == 0) begin
                d4k = j;
                check32("lat4_rdata", b4.rdata, prev_mr);
                check1("lat4_err", b4.err, 1'b0);
                b4.req0 = 0;
            end
        end
        check_int("lat1_latency", d1k + 1, 4);
        check_int("lat4_latency", d4k + 1, 7);
        check_int("lat1_cs_cycles", cs1, 1);
        check_int("lat4_cs_cycles", cs4, 4);
        $display("txn lat1 done_tick=%0d lat4 done_tick=%0d", d1k, d4k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
